// File: rtl/wave_synth_pkg.sv
// rtl/wave_synth_pkg.sv - shared mode encodings and shaping constants for the waveform synthesiser
package wave_synth_pkg;

    localparam logic [1:0] MODE_OFF = 2'd0;
    localparam logic [1:0] MODE_SQR = 2'd1;
    localparam logic [1:0] MODE_TRI = 2'd2;
    localparam logic [1:0] MODE_SAW = 2'd3;

    function automatic int calc_max(input int sample_w);
        return (1 << (sample_w - 1)) - 1;
    endfunction

    // Triangle slope: full swing over half a period.
    function automatic int calc_st(input int sample_w, input int steps);
        return (2 * calc_max(sample_w)) / (steps / 2);
    endfunction

    function automatic int calc_ss(input int sample_w, input int steps);
        return (2 * calc_max(sample_w)) / steps;
    endfunction

endpackage

// File: rtl/wave_synth_multi_channel.sv
// rtl/wave_synth_multi_channel.sv - one synth channel: step counter, phase, pending note, shaper, output register
module wave_channel
    import wave_synth_pkg::*;
#(
    parameter int DIV_W    = 20,
    parameter int SAMPLE_W = 16,
    parameter int STEPS    = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [DIV_W-1:0]    upd_div,
    input  logic [1:0]          upd_mode,
    input  logic [2:0]          vol,
    output logic [SAMPLE_W-1:0] audio,
    output logic                phase_wrap
);

    localparam int PH_W = $clog2(STEPS);
    localparam logic [PH_W-1:0] H_P    = PH_W'(STEPS / 2);
    localparam logic [PH_W-1:0] LAST_P = PH_W'(STEPS - 1);
    localparam logic signed [SAMPLE_W:0] MAX_S = (SAMPLE_W + 1)'(calc_max(SAMPLE_W));
    localparam logic signed [SAMPLE_W:0] ST_S  = (SAMPLE_W + 1)'(calc_st(SAMPLE_W, STEPS));
    localparam logic signed [SAMPLE_W:0] SS_S  = (SAMPLE_W + 1)'(calc_ss(SAMPLE_W, STEPS));
    localparam logic signed [SAMPLE_W:0] H_S   = (SAMPLE_W + 1)'(STEPS / 2);

    logic [DIV_W-1:0] step_cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pend_div;
    logic [1:0]       mode_q;
    logic [1:0]       pend_mode;
    logic             pend_valid;
    logic [PH_W-1:0]  phase;

    logic active;
    logic step_end;
    logic wrap_now;
    logic xfer;

    logic signed [SAMPLE_W:0] ph_s;
    logic signed [SAMPLE_W:0] shaped;
    logic signed [SAMPLE_W:0] shifted;

    assign active    = en && (div_q != '0) && (mode_q != MODE_OFF);
    assign step_end  = (step_cnt == div_q - DIV_W'(1));
    assign wrap_now  = active && step_end && (phase == LAST_P);
    assign upd_ready = !pend_valid;
    assign xfer      = upd_valid && !pend_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt   <= '0;
            phase      <= '0;
            div_q      <= '0;
            mode_q     <= MODE_OFF;
            pend_div   <= '0;
            pend_mode  <= MODE_OFF;
            pend_valid <= 1'b0;
            phase_wrap <= 1'b0;
        end else begin
            phase_wrap <= wrap_now;
            if (!active) begin
                // An idle channel has no boundary to wait for, so notes land at once.
                step_cnt <= '0;
                phase    <= '0;
                if (pend_valid) begin
                    div_q      <= pend_div;
                    mode_q     <= pend_mode;
                    pend_valid <= 1'b0;
                end else if (xfer) begin
                    div_q  <= upd_div;
                    mode_q <= upd_mode;
                end
            end else if (step_end) begin
                step_cnt <= '0;
                if (wrap_now) begin
                    phase <= '0;
                    if (pend_valid) begin
                        div_q      <= pend_div;
                        mode_q     <= pend_mode;
                        pend_valid <= 1'b0;
                    end else if (xfer) begin
                        div_q  <= upd_div;
                        mode_q <= upd_mode;
                    end
                end else begin
                    phase <= phase + PH_W'(1);
                end
            end else begin
                step_cnt <= step_cnt + DIV_W'(1);
            end
            if (active && xfer && !wrap_now) begin
                pend_div   <= upd_div;
                pend_mode  <= upd_mode;
                pend_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        ph_s   = (SAMPLE_W + 1)'(phase);
        shaped = '0;
        case (mode_q)
            MODE_SQR: shaped = (phase < H_P) ? MAX_S : -MAX_S;
            MODE_TRI: shaped = (phase < H_P) ? (-MAX_S + ph_s * ST_S)
                                             : (MAX_S - (ph_s - H_S) * ST_S);
            MODE_SAW: shaped = -MAX_S + ph_s * SS_S;
            default:  shaped = '0;
        endcase
        shifted = shaped >>> vol;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio <= '0;
        end else begin
            audio <= active ? shifted[SAMPLE_W-1:0] : '0;
        end
    end

endmodule

// File: rtl/wave_synth_multi.sv
// rtl/wave_synth_multi.sv - multi-channel waveform synthesiser top; one wave_channel per DAC slot
module wave_synth_multi
    import wave_synth_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int DIV_W    = 20,
    parameter int SAMPLE_W = 16,
    parameter int STEPS    = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [NUM_CH-1:0]            upd_valid,
    output logic [NUM_CH-1:0]            upd_ready,
    input  logic [NUM_CH*DIV_W-1:0]      upd_div,
    input  logic [NUM_CH*2-1:0]          upd_mode,
    input  logic [NUM_CH*3-1:0]          vol,
    output logic [NUM_CH*SAMPLE_W-1:0]   audio,
    output logic [NUM_CH-1:0]            phase_wrap
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        wave_channel #(
            .DIV_W    (DIV_W),
            .SAMPLE_W (SAMPLE_W),
            .STEPS    (STEPS)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .upd_valid  (upd_valid[c]),
            .upd_ready  (upd_ready[c]),
            .upd_div    (upd_div[c*DIV_W +: DIV_W]),
            .upd_mode   (upd_mode[c*2 +: 2]),
            .vol        (vol[c*3 +: 3]),
            .audio      (audio[c*SAMPLE_W +: SAMPLE_W]),
            .phase_wrap (phase_wrap[c])
        );
    end

endmodule

// File: doc/wave_synth_multi.md
Name: wave_synth_multi

Overview:
- Parametrised multi-channel waveform synthesiser: next generation of the single-divisor note generator.
- Each channel has its own step divisor, waveform mode (silence/square/triangle/sawtooth) and attenuation.
- Note changes use a valid/ready handshake and take effect only at a period boundary, so they are glitch-free.
- Sits between the melody sequencer and the audio DAC serialiser; one channel per DAC slot.

Parameters:
- NUM_CH, 2: number of independent channels (ch0 = left, ch1 = right by default).
- DIV_W, 20: width of the per-channel step divisor.
- SAMPLE_W, 16: signed output sample width.
- STEPS, 40: samples per waveform period; must be even and >= 4.

Ports:
- clk  in  1  system clock from crystal.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  global run enable; low forces all channels idle.
- upd_valid  in  NUM_CH  per-channel note-update request.
- upd_ready  out  NUM_CH  per-channel: update can be accepted.
- upd_div  in  NUM_CH*DIV_W  clock cycles per sample step; 0 = channel off.
- upd_mode  in  NUM_CH*2  0 silence, 1 square, 2 triangle, 3 sawtooth.
- vol  in  NUM_CH*3  live arithmetic right-shift attenuation, 0..7.
- audio  out  NUM_CH*SAMPLE_W  signed two's-complement samples, registered.
- phase_wrap  out  NUM_CH  one-cycle pulse when phase returns to 0.

Behaviour:
- Reset, asynchronous and active-low: applies to all channels.
  - step_cnt = 0, phase = 0, div = 0, mode = 0.
  - pending register empty; audio = 0; phase_wrap = 0; upd_ready = 1.
- Active channel: en = 1, div != 0, mode != 0.
  - step_cnt counts 0..div-1.
  - When step_cnt == div-1: step_cnt <= 0 and phase <= phase+1.
  - Phase wraps from STEPS-1 to 0; phase_wrap pulses in the cycle the wrap is registered.
  - Full period = div*STEPS cycles.
- Inactive channel: step_cnt and phase held at 0; audio = 0; no phase_wrap pulses.
- Shaping, with MAX = 2^(SAMPLE_W-1)-1, H = STEPS/2, ST = (2*MAX)/H, SS = (2*MAX)/STEPS as integer localparams:
  - square: phase < H gives +MAX, else -MAX.
  - triangle: phase < H gives -MAX + phase*ST; else MAX - (phase-H)*ST.
  - sawtooth: -MAX + phase*SS.
  - All shaping computed at SAMPLE_W+1 bits, then truncated; no overflow is possible by construction.
- Output: audio <= shaped(phase) >>> vol, arithmetic shift.
  - Registered every cycle; latency 1 cycle from a phase change.
  - vol takes effect on the next cycle, not deferred to the period boundary.
- Update handshake, per channel; a transfer occurs when upd_valid & upd_ready.
  - Channel inactive: new div/mode are loaded next cycle; step_cnt = 0, phase = 0.
  - Channel active and transfer coincides with a wrap cycle: applied at that wrap; pending stays empty.
  - Channel active otherwise: captured into pending; upd_ready = 0 until applied.
  - Pending is applied on the next wrap (phase <= 0, div/mode <= pending, step_cnt <= 0); upd_ready returns to 1 the following cycle.
- Writing div = 0 via update on an active channel takes effect at the next wrap, then the channel goes silent.
- en falling: all channels go idle next cycle (phase = 0, audio = 0).
  - Pending updates are applied immediately, because the channel is now inactive.
- en rising: channels restart from phase 0.
- Reset mid-operation: everything returns to reset values immediately; any pending update is discarded.
- Channels are fully independent; no shared arbitration.

Decomposition:
- Shared package wave_synth_pkg holds:
  - mode encoding constants MODE_OFF/SQR/TRI/SAW;
  - MAX, ST, SS localparam functions of SAMPLE_W/STEPS.
- Sub-module wave_channel holds one channel's counter, phase, pending register, shaper and output register.
- Top level instantiates NUM_CH copies with a generate loop and slices the flattened buses.

Test Plan:
- Reset, then en = 1, ch0 update div = 2, mode = square, vol = 0 -> audio[0] = +32767 for 40 cycles, then -32767 for 40 cycles; phase_wrap[0] every 80 cycles; ch1 stays 0.
- Triangle, div = 1, vol = 1 -> first sample after load is -16384; the sample at phase 20 is 32767>>>1 = 16383; period 40 cycles.
- Sawtooth, div = 3 -> audio steps by 1638 every 3 cycles, from -32767 up to 31115, then back to -32767 with a phase_wrap pulse.
- Update ch0 mid-period to div = 5 -> upd_ready[0] = 0 until the wrap; the old period completes unaltered; the new step length of 5 starts at phase 0; upd_ready[0] = 1 one cycle later.
- Both channels active with div 2/3, then en dropped at an arbitrary cycle -> both audio = 0 next cycle, both phases restart at 0 when en is reasserted.
- Reset asserted while a pending update exists -> all outputs 0 immediately, upd_ready = all-ones, and the pending update is never applied.
